lcd_mode_display: RTL and testbench



---
 rtl/lcd_pkg.sv | 34 +++
 rtl/mode_text_rom.sv | 26 ++
 rtl/lcd_mode_display.sv | 130 +++++++++++++
 tb/tb_lcd_mode_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and text helpers for the mode-display LCD driver.
package lcd_pkg;

  localparam logic [7:0] LCD_FSET  = 8'h38;
  localparam logic [7:0] LCD_DON   = 8'h0C;
  localparam logic [7:0] LCD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CLR   = 8'h01;
  localparam logic [7:0] LCD_L1    = 8'h80;
  localparam logic [7:0] LCD_L2    = 8'hC0;

  localparam logic [1:0] MODE_WATCH     = 2'b00;
  localparam logic [1:0] MODE_ALARM     = 2'b01;
  localparam logic [1:0] MODE_STOPWATCH = 2'b10;

  typedef enum logic [3:0] {
    PWR, FSET, DON, ENTRY, CLR, CLR_WAIT, L1_ADDR, L1, L2_ADDR, L2, IDLE
  } state_t;

  // 16-character panel lines, leftmost character in the top byte.
  localparam logic [127:0] STR_L1        = "CURRENT MODE:   ";
  localparam logic [127:0] STR_WATCH     = "WATCH           ";
  localparam logic [127:0] STR_ALARM     = "ALARM           ";
  localparam logic [127:0] STR_STOPWATCH = "STOPWATCH       ";
  localparam logic [127:0] STR_DASH      = "----            ";

  function automatic logic [7:0] str_char(input logic [127:0] s, input logic [3:0] idx);
    return s[{~idx, 3'b000} +: 8];
  endfunction

  function automatic logic is_write(input state_t s);
    return s inside {FSET, DON, ENTRY, CLR, L1_ADDR, L1, L2_ADDR, L2};
  endfunction

endpackage

// File: rtl/mode_text_rom.sv
// Combinational character ROM: line 1 banner or the line-2 text for the shown mode.
module mode_text_rom
  import lcd_pkg::*;
(
  input  logic       line_sel,
  input  logic [1:0] shown_mode,
  input  logic [3:0] char_idx,
  output logic [7:0] char_code
);

  logic [127:0] line_str;

  always_comb begin
    line_str = STR_L1;
    if (line_sel) begin
      case (shown_mode)
        MODE_WATCH:     line_str = STR_WATCH;
        MODE_ALARM:     line_str = STR_ALARM;
        MODE_STOPWATCH: line_str = STR_STOPWATCH;
        default:        line_str = STR_DASH;
      endcase
    end
    char_code = str_char(line_str, char_idx);
  end

endmodule

// File: rtl/lcd_mode_display.sv
// HD44780 8-bit write-only driver: power-up init, banner on line 1, current mode on line 2,
// and a line-2 rewrite whenever the mode differs from what is displayed.
module lcd_mode_display
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC  = 20,
  parameter int CLR_WAIT_CYC = 2
)(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int WAIT_MAX = (POWERUP_CYC > CLR_WAIT_CYC) ? POWERUP_CYC : CLR_WAIT_CYC;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(POWERUP_CYC - 1);
  localparam logic [WAIT_W-1:0] CLR_LAST = WAIT_W'(CLR_WAIT_CYC - 1);

  state_t            state, state_n;
  logic [1:0]        phase, phase_n;
  logic [3:0]        idx, idx_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  logic [1:0]        shown_mode;
  logic              e_n, rs_n, busy_n;
  logic [7:0]        data_n, rom_char;
  logic              last_phase;

  assign lcd_rw     = 1'b0;
  assign last_phase = (phase == 2'd2);

  // Outputs are decoded from the next state so they line up with the state they belong to.
  mode_text_rom u_rom (
    .line_sel   (state_n == L2),
    .shown_mode (shown_mode),
    .char_idx   (idx_n),
    .char_code  (rom_char)
  );

  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = idx;
    cnt_n   = cnt;
    if (is_write(state)) phase_n = last_phase ? 2'd0 : phase + 2'd1;
    case (state)
      PWR: begin
        if (cnt == PWR_LAST) begin
          state_n = FSET;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FSET:  if (last_phase) state_n = DON;
      DON:   if (last_phase) state_n = ENTRY;
      ENTRY: if (last_phase) state_n = CLR;
      CLR:   if (last_phase) state_n = (CLR_WAIT_CYC > 0) ? CLR_WAIT : L1_ADDR;
      CLR_WAIT: begin
        if (cnt == CLR_LAST) begin
          state_n = L1_ADDR;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      L1_ADDR: if (last_phase) state_n = L1;
      L1: begin
        if (last_phase) begin
          idx_n = idx + 4'd1;
          if (idx == 4'd15) state_n = L2_ADDR;
        end
      end
      L2_ADDR: if (last_phase) state_n = L2;
      L2: begin
        if (last_phase) begin
          idx_n = idx + 4'd1;
          if (idx == 4'd15) state_n = IDLE;
        end
      end
      IDLE:    if (mode != shown_mode) state_n = L2_ADDR;
      default: state_n = PWR;
    endcase

    e_n    = is_write(state_n) && (phase_n == 2'd1);
    rs_n   = lcd_rs;
    data_n = lcd_data;
    busy_n = (state_n != IDLE);
    case (state_n)
      FSET:    begin rs_n = 1'b0; data_n = LCD_FSET;  end
      DON:     begin rs_n = 1'b0; data_n = LCD_DON;   end
      ENTRY:   begin rs_n = 1'b0; data_n = LCD_ENTRY; end
      CLR:     begin rs_n = 1'b0; data_n = LCD_CLR;   end
      L1_ADDR: begin rs_n = 1'b0; data_n = LCD_L1;    end
      L2_ADDR: begin rs_n = 1'b0; data_n = LCD_L2;    end
      L1, L2:  begin rs_n = 1'b1; data_n = rom_char;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PWR;
      phase      <= 2'd0;
      idx        <= 4'd0;
      cnt        <= '0;
      shown_mode <= MODE_WATCH;
      lcd_e      <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      busy       <= 1'b1;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      lcd_e    <= e_n;
      lcd_rs   <= rs_n;
      lcd_data <= data_n;
      busy     <= busy_n;
      // Line 2 text is frozen for the whole rewrite once its address command starts.
      if (state_n == L2_ADDR && state != L2_ADDR) shown_mode <= mode;
    end
  end

endmodule

// File: tb/tb_lcd_mode_display.sv
// Directed bench for lcd_mode_display: records every enable-high cycle and checks the write stream.
module tb_lcd_mode_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       lcd_e, lcd_rs, lcd_rw, busy;
  logic [7:0] lcd_data;

  lcd_mode_display #(.POWERUP_CYC(20), .CLR_WAIT_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] d;
  } wr_t;

  wr_t  got[$];
  wr_t  exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc, fall_cyc, rise_cyc;
  logic prev_e, prev_busy;
  bit   rw_seen, e_long;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    wr_t w;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (lcd_rw !== 1'b0) rw_seen = 1'b1;
      if (lcd_e === 1'b1) begin
        w.cyc = cyc; w.rs = lcd_rs; w.d = lcd_data;
        got.push_back(w);
        if (prev_e === 1'b1) e_long = 1'b1;
      end
      if (prev_busy === 1'b1 && busy === 1'b0) fall_cyc = cyc;
      if (prev_busy === 1'b0 && busy === 1'b1) rise_cyc = cyc;
      prev_e    = lcd_e;
      prev_busy = busy;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int k = 0;
    do begin
      step(1);
      k++;
    end while (busy !== 1'b0 && k < limit);
    chk({tag, "_idle_reached"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst       = 1'b1;
    cyc       = 0;
    prev_e    = 1'b0;
    prev_busy = 1'b1;
    fall_cyc  = -1;
    rise_cyc  = -1;
    got.delete();
    exp.delete();
  endtask

  task automatic add(input logic rs, input logic [7:0] d);
    wr_t w;
    w.cyc = 0; w.rs = rs; w.d = d;
    exp.push_back(w);
  endtask

  task automatic add_line(input string s);
    for (int i = 0; i < 16; i++) add(1'b1, (i < s.len()) ? s[i] : 8'h20);
  endtask

  task automatic add_init_and_l1();
    add(1'b0, 8'h38); add(1'b0, 8'h0C); add(1'b0, 8'h06); add(1'b0, 8'h01);
    add(1'b0, 8'h80);
    add_line("CURRENT MODE:   ");
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), {23'd0, got[i].rs, got[i].d}, {23'd0, exp[i].rs, exp[i].d});
    got.delete();
    exp.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rw_seen = 1'b0;
    e_long  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_e",    {31'd0, lcd_e},  32'd0);
    chk("rst_rs",   {31'd0, lcd_rs}, 32'd0);
    chk("rst_rw",   {31'd0, lcd_rw}, 32'd0);
    chk("rst_data", {24'd0, lcd_data}, 32'h00);
    chk("rst_busy", {31'd0, busy},   32'd1);

    // Power-up sequence with mode WATCH
    release_rst();
    step(20);
    chk("pwr_no_writes", got.size(), 32'd0);
    step(116);
    chk("t1_first_e_cyc", (got.size() > 0) ? got[0].cyc : -1, 32'd21);
    chk("t1_busy_fall", fall_cyc, 32'd136);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    add_init_and_l1();
    add(1'b0, 8'hC0); add_line("WATCH");
    cmp_writes("t1");

    // Mode change while idle: line 2 only
    mode = 2'b10;
    wait_idle("t2", 100);
    chk("t2_busy_rise", rise_cyc, 32'd137);
    chk("t2_busy_len", fall_cyc - rise_cyc, 32'd51);
    chk("t2_first_e_cyc", (got.size() > 0) ? got[0].cyc : -1, 32'd138);
    add(1'b0, 8'hC0); add_line("STOPWATCH");
    cmp_writes("t2");

    // Mode changes during line 1 and during line 2
    rst = 1'b0;
    mode = 2'b00;
    repeat (2) @(negedge clk);
    release_rst();
    step(50);
    mode = 2'b01;
    step(50);
    mode = 2'b10;
    step(36);
    chk("t3_first_idle_busy", {31'd0, busy}, 32'd0);
    chk("t3_first_fall", fall_cyc, 32'd136);
    wait_idle("t3", 100);
    chk("t3_second_fall", fall_cyc, 32'd188);
    step(20);
    chk("t3_stays_idle", {31'd0, busy}, 32'd0);
    add_init_and_l1();
    add(1'b0, 8'hC0); add_line("ALARM");
    add(1'b0, 8'hC0); add_line("STOPWATCH");
    cmp_writes("t3");

    // Mode code 11, then a pulse that returns to the shown value mid-refresh
    mode = 2'b11;
    wait_idle("t4a", 100);
    add(1'b0, 8'hC0); add_line("----");
    cmp_writes("t4a");
    mode = 2'b00;
    step(5);
    mode = 2'b01;
    step(10);
    mode = 2'b00;
    wait_idle("t4b", 100);
    step(30);
    chk("t4b_no_extra_busy", {31'd0, busy}, 32'd0);
    add(1'b0, 8'hC0); add_line("WATCH");
    cmp_writes("t4b");

    // Asynchronous reset during a line-1 enable pulse
    rst = 1'b0;
    repeat (2) @(negedge clk);
    release_rst();
    step(38);
    chk("t5_e_high_before_rst", {31'd0, lcd_e}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_async_e",    {31'd0, lcd_e},    32'd0);
    chk("t5_async_busy", {31'd0, busy},     32'd1);
    chk("t5_async_data", {24'd0, lcd_data}, 32'h00);
    release_rst();
    step(20);
    chk("t5_pwr_no_writes", got.size(), 32'd0);
    step(1);
    chk("t5_first_e_cyc", (got.size() > 0) ? got[0].cyc : -1, 32'd21);
    wait_idle("t5", 200);
    chk("t5_busy_fall", fall_cyc, 32'd136);
    add_init_and_l1();
    add(1'b0, 8'hC0); add_line("WATCH");
    cmp_writes("t5");

    chk("rw_always_zero", {31'd0, rw_seen}, 32'd0);
    chk("e_single_cycle", {31'd0, e_long},  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
